// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vend_pkg
// Description : Shared types and helpers for the parametrised vending FSM.
//               coin_t  - 2-bit coin code from the coin acceptor
//               state_t - controller state encoding
//               coin_value() - maps a coin code to its credit value
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_2    = 2'b10,
    COIN_3    = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    VEND   = 2'b01,
    REFUND = 2'b10
  } state_t;

  // Coin values are passed in so each instance can carry its own tariff.
  function automatic int coin_value(input coin_t c, input int v1, input int v2, input int v3);
    int val;
    case (c)
      COIN_1:  val = v1;
      COIN_2:  val = v2;
      COIN_3:  val = v3;
      default: val = 0;
    endcase
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_stock_counter.sv
`default_nettype none
// ============================================================================
// Module      : vend_stock_counter
// Description : Remaining-product counter for the vending controller.
//               Loads STOCK_INIT on reset or restock, decrements once per
//               vend, and flags sold_out when empty.
// Ports       : clock    - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               restock  - reload to STOCK_INIT (minus a same-edge vend)
//               dec      - one product dispensed at this edge
//               stock    - remaining products
//               sold_out - stock == 0
// Revision    : 1.0 - initial release
// ============================================================================
module vend_stock_counter #(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               restock,
  input  logic               dec,
  output logic [STOCK_W-1:0] stock,
  output logic               sold_out
);

  localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] ONE      = STOCK_W'(1);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stock <= INIT_VAL;
    end else if (restock) begin
      // A vend on the restock edge consumes one of the freshly loaded items.
      if (dec && (INIT_VAL != '0)) stock <= INIT_VAL - ONE;
      else                         stock <= INIT_VAL;
    end else if (dec && (stock != '0)) begin
      stock <= stock - ONE;
    end
  end

  assign sold_out = (stock == '0);

endmodule
`default_nettype wire

// File: rtl/param_vending_fsm.sv
`default_nettype none
// ============================================================================
// Module      : param_vending_fsm
// Description : Coin-operated vending controller with configurable price,
//               coin values and stock. Accumulates credit, dispenses one
//               drop pulse per vend (back-to-back while credit covers PRICE),
//               returns leftover credit as one change pulse per unit, and
//               rejects coins while sold out or refunding.
// Ports       : clock    - system clock, rising edge
//               reset    - asynchronous active-low reset
//               coin     - coin code (00 none, 01/10/11 coin this cycle)
//               refund   - request return of current credit
//               restock  - reload stock to STOCK_INIT
//               credit   - current credit (registered)
//               drop     - one-cycle pulse per product dispensed
//               change   - one-cycle pulse per credit unit returned
//               reject   - one-cycle pulse, previous-cycle coin returned
//               sold_out - stock == 0
//               stock    - remaining products
// Revision    : 1.0 - initial release
// ============================================================================
module param_vending_fsm
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 4,
  parameter int PRICE      = 4,
  parameter int COIN1_VAL  = 1,
  parameter int COIN2_VAL  = 3,
  parameter int COIN3_VAL  = 5,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                refund,
  input  logic                restock,
  output logic [CREDIT_W-1:0] credit,
  output logic                drop,
  output logic                change,
  output logic                reject,
  output logic                sold_out,
  output logic [STOCK_W-1:0]  stock
);

  localparam logic [CREDIT_W:0]   PRICE_EXT = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE       = CREDIT_W'(1);

  state_t            state;
  logic [CREDIT_W:0] sum;
  logic              coin_in;
  logic              vend_ok;
  logic              refund_go;
  logic              take;

  // Sum is one bit wider than credit so the PRICE comparison cannot alias.
  always_comb begin
    sum       = {1'b0, credit} +
                (CREDIT_W+1)'(coin_value(coin_t'(coin), COIN1_VAL, COIN2_VAL, COIN3_VAL));
    coin_in   = (coin != 2'b00);
    vend_ok   = (sum >= PRICE_EXT) && !sold_out;
    refund_go = (state == IDLE) && refund && (credit != '0);
    take      = vend_ok && (((state == IDLE) && !refund_go) || (state == VEND));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      credit <= '0;
      drop   <= 1'b0;
      change <= 1'b0;
      reject <= 1'b0;
    end else begin
      drop   <= 1'b0;
      change <= 1'b0;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (refund_go) begin
            // Refund takes priority; a coin in the same cycle is bounced.
            state  <= REFUND;
            change <= 1'b1;
            reject <= coin_in;
          end else if (sold_out) begin
            reject <= coin_in;
          end else if (take) begin
            credit <= CREDIT_W'(sum - PRICE_EXT);
            state  <= VEND;
            drop   <= 1'b1;
          end else begin
            credit <= CREDIT_W'(sum);
          end
        end
        VEND: begin
          // Refund requests are not honoured while dispensing.
          if (sold_out) begin
            reject <= coin_in;
            state  <= IDLE;
          end else if (take) begin
            credit <= CREDIT_W'(sum - PRICE_EXT);
            drop   <= 1'b1;
          end else begin
            credit <= CREDIT_W'(sum);
            state  <= IDLE;
          end
        end
        REFUND: begin
          reject <= coin_in;
          if (credit <= ONE) begin
            credit <= '0;
            state  <= IDLE;
          end else begin
            credit <= credit - ONE;
            change <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  vend_stock_counter #(
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .clock    (clock),
    .rst_n    (reset),
    .restock  (restock),
    .dec      (take),
    .stock    (stock),
    .sold_out (sold_out)
  );

`ifndef SYNTHESIS
  // Credit accepted from a coin must fit the credit register.
  always_ff @(posedge clock) begin
    if (reset && (state != REFUND) && !refund_go && !sold_out) begin
      assert (sum[CREDIT_W] == 1'b0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_vending_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_vending_fsm
// Description : Directed scoreboard bench for param_vending_fsm. Unit A uses
//               default parameters, unit B uses STOCK_INIT=1 for sold-out
//               behaviour. Expected outputs are queued as each step is
//               driven and popped after the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_vending_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] coin_a, coin_b;
  logic       refund_a, refund_b, restock_a, restock_b;
  logic [3:0] credit_a, credit_b, stock_a, stock_b;
  logic       drop_a, drop_b, change_a, change_b, reject_a, reject_b;
  logic       sold_a, sold_b;

  typedef struct packed {
    logic [3:0] credit;
    logic       drop;
    logic       change;
    logic       reject;
    logic       sold_out;
    logic [3:0] stock;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  param_vending_fsm dut_a (
    .clock(clock), .reset(reset), .coin(coin_a), .refund(refund_a), .restock(restock_a),
    .credit(credit_a), .drop(drop_a), .change(change_a), .reject(reject_a),
    .sold_out(sold_a), .stock(stock_a)
  );

  param_vending_fsm #(.STOCK_INIT(1)) dut_b (
    .clock(clock), .reset(reset), .coin(coin_b), .refund(refund_b), .restock(restock_b),
    .credit(credit_b), .drop(drop_b), .change(change_b), .reject(reject_b),
    .sold_out(sold_b), .stock(stock_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare(input bit u, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty observed=none expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    if (!u) begin
      chk({tag, ".credit"}, {4'b0, credit_a}, {4'b0, e.credit});
      chk({tag, ".drop"},   {7'b0, drop_a},   {7'b0, e.drop});
      chk({tag, ".change"}, {7'b0, change_a}, {7'b0, e.change});
      chk({tag, ".reject"}, {7'b0, reject_a}, {7'b0, e.reject});
      chk({tag, ".sold"},   {7'b0, sold_a},   {7'b0, e.sold_out});
      chk({tag, ".stock"},  {4'b0, stock_a},  {4'b0, e.stock});
    end else begin
      chk({tag, ".credit"}, {4'b0, credit_b}, {4'b0, e.credit});
      chk({tag, ".drop"},   {7'b0, drop_b},   {7'b0, e.drop});
      chk({tag, ".change"}, {7'b0, change_b}, {7'b0, e.change});
      chk({tag, ".reject"}, {7'b0, reject_b}, {7'b0, e.reject});
      chk({tag, ".sold"},   {7'b0, sold_b},   {7'b0, e.sold_out});
      chk({tag, ".stock"},  {4'b0, stock_b},  {4'b0, e.stock});
    end
  endtask

  task automatic idle_inputs();
    coin_a = 2'b00; refund_a = 1'b0; restock_a = 1'b0;
    coin_b = 2'b00; refund_b = 1'b0; restock_b = 1'b0;
  endtask

  // Drive one cycle of stimulus on unit u, queue the expected post-edge state.
  task automatic step(input bit u, input logic [1:0] c, input logic rf, input logic rs,
                      input logic [3:0] ecr, input logic ed, input logic ec, input logic erj,
                      input logic eso, input logic [3:0] est, input string tag);
    @(negedge clock);
    idle_inputs();
    if (!u) begin coin_a = c; refund_a = rf; restock_a = rs; end
    else    begin coin_b = c; refund_b = rf; restock_b = rs; end
    sb.push_back('{ecr, ed, ec, erj, eso, est});
    @(posedge clock);
    #1;
    idle_inputs();
    compare(u, tag);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8});
    compare(1'b0, "rst_a");
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1});
    compare(1'b1, "rst_b");
    @(negedge clock);
    reset = 1'b1;

    // Four 1-unit coins reach PRICE on the fourth.
    step(0, 2'b01, 0, 0, 4'd1, 0, 0, 0, 0, 4'd8, "t1_c1");
    step(0, 2'b01, 0, 0, 4'd2, 0, 0, 0, 0, 4'd8, "t1_c2");
    step(0, 2'b01, 0, 0, 4'd3, 0, 0, 0, 0, 4'd8, "t1_c3");
    step(0, 2'b01, 0, 0, 4'd0, 1, 0, 0, 0, 4'd7, "t1_vend");
    step(0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 4'd7, "t1_idle");

    // Credit 3 + coin 5 = 8 -> two back-to-back vends.
    step(0, 2'b10, 0, 0, 4'd3, 0, 0, 0, 0, 4'd7, "t2_c3");
    step(0, 2'b11, 0, 0, 4'd4, 1, 0, 0, 0, 4'd6, "t2_vend1");
    step(0, 2'b00, 0, 0, 4'd0, 1, 0, 0, 0, 4'd5, "t2_vend2");
    step(0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 4'd5, "t2_idle");

    // Coins inserted while in VEND extend the vend run.
    step(0, 2'b01, 0, 0, 4'd1, 0, 0, 0, 0, 4'd5, "tv_c1");
    step(0, 2'b11, 0, 0, 4'd2, 1, 0, 0, 0, 4'd4, "tv_vend1");
    step(0, 2'b10, 0, 0, 4'd1, 1, 0, 0, 0, 4'd3, "tv_vend2");
    step(0, 2'b00, 0, 0, 4'd1, 0, 0, 0, 0, 4'd3, "tv_idle");

    // Refund of 3 credits with coin bounced on entry and during refund.
    step(0, 2'b01, 0, 0, 4'd2, 0, 0, 0, 0, 4'd3, "t3_c2");
    step(0, 2'b01, 0, 0, 4'd3, 0, 0, 0, 0, 4'd3, "t3_c3");
    step(0, 2'b10, 1, 0, 4'd3, 0, 1, 1, 0, 4'd3, "t3_ref3");
    step(0, 2'b01, 0, 0, 4'd2, 0, 1, 1, 0, 4'd3, "t3_ref2");
    step(0, 2'b00, 0, 0, 4'd1, 0, 1, 0, 0, 4'd3, "t3_ref1");
    step(0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 4'd3, "t3_done");

    // Restock on the vend edge, then refund with zero credit.
    step(0, 2'b10, 0, 0, 4'd3, 0, 0, 0, 0, 4'd3, "t6_c3");
    step(0, 2'b01, 0, 1, 4'd0, 1, 0, 0, 0, 4'd7, "t6_rsvend");
    step(0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 4'd7, "t6_idle");
    step(0, 2'b01, 1, 0, 4'd1, 0, 0, 0, 0, 4'd7, "t6_ref0");
    step(0, 2'b00, 0, 0, 4'd1, 0, 0, 0, 0, 4'd7, "t6_nochg");

    // Asynchronous reset in the middle of a refund.
    step(0, 2'b10, 0, 0, 4'd0, 1, 0, 0, 0, 4'd6, "t5_vend");
    step(0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0, 4'd6, "t5_idle");
    step(0, 2'b10, 0, 0, 4'd3, 0, 0, 0, 0, 4'd6, "t5_c3");
    step(0, 2'b00, 1, 0, 4'd3, 0, 1, 0, 0, 4'd6, "t5_ref");
    #2 reset = 1'b0;
    #1;
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8});
    compare(1'b0, "t5_async_a");
    sb.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1});
    compare(1'b1, "t5_async_b");
    @(negedge clock);
    reset = 1'b1;

    // Single-item unit: sell out, bounce coins, restock.
    step(1, 2'b11, 0, 0, 4'd1, 1, 0, 0, 1, 4'd0, "t4_vend");
    step(1, 2'b10, 0, 0, 4'd1, 0, 0, 1, 1, 4'd0, "t4_rej_vend");
    step(1, 2'b10, 0, 0, 4'd1, 0, 0, 1, 1, 4'd0, "t4_rej_idle");
    step(1, 2'b00, 0, 1, 4'd1, 0, 0, 0, 0, 4'd1, "t4_restock");
    step(1, 2'b00, 0, 0, 4'd1, 0, 0, 0, 0, 4'd1, "t4_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_vending_fsm.md
Name: param_vending_fsm

Overview:
Parametrised successor to the lab coin-operated soda FSM.
- Accepts 2-bit coin codes and accumulates credit against a configurable PRICE.
- Dispatches one drop pulse per vend and supports back-to-back vends when credit still covers PRICE.
- Returns leftover credit on request as one change pulse per credit unit.
- Tracks remaining stock, rejects coins when sold out or while refunding, and supports restock.

Parameters:
CREDIT_W, 4, width of credit register; must satisfy PRICE-1+max(COINx_VAL) <= 2**CREDIT_W-1
PRICE, 4, credits consumed per vend; must be >= 1
COIN1_VAL, 1, credit value of coin code 2'b01
COIN2_VAL, 3, credit value of coin code 2'b10
COIN3_VAL, 5, credit value of coin code 2'b11
STOCK_W, 4, width of stock counter
STOCK_INIT, 8, stock after reset/restock; must be <= 2**STOCK_W-1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
coin  input  2  00 none, 01/10/11 coin inserted this cycle (one coin per cycle)
refund  input  1  request return of current credit
restock  input  1  reload stock to STOCK_INIT
credit  output  CREDIT_W  current credit (registered)
drop  output  1  high one cycle per product dispensed
change  output  1  high one cycle per credit unit returned
reject  output  1  registered one-cycle pulse: coin from previous cycle physically returned, not credited
sold_out  output  1  stock == 0
stock  output  STOCK_W  remaining products

Behaviour:
- reset low (async): state IDLE, credit 0, stock STOCK_INIT, drop/change/reject 0; held while low.
- States:
  - IDLE: accumulate.
  - VEND: drop=1.
  - REFUND: change=1.
  - drop and change are Moore outputs of state.
- sum = credit + coinval(coin), computed CREDIT_W+1 bits wide. vend_ok = (sum >= PRICE) && stock != 0.
- IDLE:
  - refund=1 && credit>0: next REFUND; any coin this cycle rejected (refund wins).
  - refund=1 && credit==0: no-op; coin processed normally.
  - sold_out: coin rejected, credit unchanged.
  - else if vend_ok: credit <= sum-PRICE, stock decrements, next VEND.
  - else: credit <= sum.
- VEND:
  - drop=1 for exactly this cycle.
  - coin accepted as in IDLE (sum, vend_ok); vend_ok => stay VEND (another drop next cycle), credit <= sum-PRICE, stock decrements.
  - else next IDLE, credit <= sum.
  - refund ignored in VEND.
  - coin rejected if sold_out.
- REFUND:
  - change=1 each cycle; credit decrements by 1 per edge.
  - when credit==1, next IDLE (credit 0).
  - N credits => exactly N consecutive change pulses.
  - coins rejected.
- Latency: coin at edge k => credit/drop update visible after edge k; reject visible after edge k, for one cycle.
- restock=1: stock <= STOCK_INIT - (vend at same edge ? 1 : 0); any state; no effect on credit/state.
- Credit never wraps (guaranteed by parameter constraint while accepting); assertion required.
- Stock never decrements below 0 (vend_ok requires stock != 0).

Decomposition:
- Package vend_pkg holds:
  - coin_t enum (COIN_NONE, COIN_1, COIN_2, COIN_3)
  - state_t enum (IDLE, VEND, REFUND)
  - function coin_value(coin_t, parameters) returning credit units
- Sub-module vend_stock_counter (STOCK_W, STOCK_INIT): async active-low reset, restock load, decrement enable, sold_out flag.
- FSM, credit register and reject register stay in the top.

Test Plan:
1. Reset; coin 01 four cycles -> credit 1,2,3,0; drop high one cycle after 4th coin; stock 8->7.
2. Credit 3; coin 11 -> sum 8: VEND, credit 4, drop; next cycle VEND again, credit 0, drop; drop high 2 cycles, stock -2.
3. Credit 3; refund=1 with coin 10 same cycle -> reject pulse; change high 3 cycles, credit 3,2,1 then 0 in IDLE; coin 01 during REFUND -> reject.
4. STOCK_INIT=1: vend once -> sold_out=1; coin 10 -> reject, credit unchanged; restock -> sold_out 0, stock 1 next cycle.
5. reset driven low mid-REFUND between clock edges -> credit 0, change 0, stock STOCK_INIT immediately without a clock edge.
6. Restock on the same edge as a vend -> stock = STOCK_INIT-1; refund with credit 0 plus coin 01 -> credit 1, no change pulse.
